axi_slave_data_mem: RTL



---
 rtl/axi_slave_data_pkg.sv | 36 +++
 rtl/axi_slave_data_ram.sv | 30 +++
 rtl/axi_slave_data_mem.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_data_pkg.sv
// Shared types and address helper for the AXI4 data-memory slave.
// Burst, response and FSM encodings live here so the top and the bench agree on them.
package axi_slave_data_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wstate_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

    // INCR successor: align the current address down to the transfer size, then step by it.
    function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [2:0] size);
        logic [63:0] step;
        step = 64'd1 << size;
        return (addr & ~(step - 64'd1)) + step;
    endfunction

endpackage

// File: rtl/axi_slave_data_ram.sv
// Bus-word storage with a byte-enabled write port and an asynchronous read port.
// The array is intentionally not reset so contents survive a bus reset.
module axi_slave_data_ram #(
    parameter int DW    = 32,
    parameter int WORDS = 1024,
    parameter int IW    = 10
) (
    input  logic            clk,
    input  logic            we,
    input  logic [IW-1:0]   waddr,
    input  logic [DW/8-1:0] wstrb,
    input  logic [DW-1:0]   wdata,
    input  logic [IW-1:0]   raddr,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem_r [WORDS];

    // Byte-lane write: each strobe bit updates its own lane only.
    always_ff @(posedge clk) begin
        for (int b = 0; b < DW/8; b++) begin
            if (we && wstrb[b]) begin
                mem_r[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/axi_slave_data_mem.sv
// AXI4 slave backed by a byte-addressable memory; independent write and read FSMs,
// one outstanding burst each, FIXED/INCR bursts, narrow transfers and byte strobes.
module axi_slave_data_mem
    import axi_slave_data_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int MEM_WORDS          = 1024
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int DW  = C_S_AXI_DATA_WIDTH;
    localparam int AW  = C_S_AXI_ADDR_WIDTH;
    localparam int IDW = C_S_AXI_ID_WIDTH;
    localparam int BB  = $clog2(DW/8);
    localparam int IW  = $clog2(MEM_WORDS);

    // WRAP, the reserved encoding and oversize transfers are all answered with SLVERR.
    function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size);
        return (burst[1] == 1'b1) || (int'(size) > BB);
    endfunction

    function automatic logic [AW-1:0] step_addr(input logic [AW-1:0] addr, input logic [2:0] size,
                                                 input logic incr);
        return incr ? AW'(next_addr(64'(addr), size)) : addr;
    endfunction

    wstate_e          wstate_r;
    logic [IDW-1:0]   wid_r;
    logic [AW-1:0]    waddr_r;
    logic [7:0]       wlen_r, wcnt_r;
    logic [2:0]       wsize_r;
    logic             wincr_r, werr_r, wlast_err_r;
    logic             awready_r, wready_r, bvalid_r;
    logic [1:0]       bresp_r;

    rstate_e          rstate_r;
    logic [IDW-1:0]   rid_r;
    logic [AW-1:0]    raddr_r;
    logic [7:0]       rlen_r, rcnt_r;
    logic [2:0]       rsize_r;
    logic             rincr_r, rerr_r;
    logic             arready_r, rvalid_r, rlast_r;
    logic [1:0]       rresp_r;
    logic [DW-1:0]    rdata_r;

    logic             aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, w_final_s, w_lastbad_s, ar_err_s;
    logic [IW-1:0]    ram_raddr_s;
    logic [DW-1:0]    ram_rdata_s;

    assign aw_hs_s     = S_AXI_AWVALID & awready_r;
    assign w_hs_s      = S_AXI_WVALID & wready_r;
    assign b_hs_s      = bvalid_r & S_AXI_BREADY;
    assign ar_hs_s     = S_AXI_ARVALID & arready_r;
    assign r_hs_s      = rvalid_r & S_AXI_RREADY;
    assign w_final_s   = (wcnt_r == wlen_r);
    assign w_lastbad_s = (S_AXI_WLAST != w_final_s);
    assign ar_err_s    = burst_err(S_AXI_ARBURST, S_AXI_ARSIZE);

    // Beat 0 is fetched straight from ARADDR so its data is ready the cycle after AR.
    always_comb begin
        if (rstate_r == R_IDLE) begin
            ram_raddr_s = S_AXI_ARADDR[BB +: IW];
        end else begin
            ram_raddr_s = raddr_r[BB +: IW];
        end
    end

    axi_slave_data_ram #(.DW(DW), .WORDS(MEM_WORDS), .IW(IW)) u_ram (
        .clk   (ACLK),
        .we    (w_hs_s & ~werr_r),
        .waddr (waddr_r[BB +: IW]),
        .wstrb (S_AXI_WSTRB),
        .wdata (S_AXI_WDATA),
        .raddr (ram_raddr_s),
        .rdata (ram_rdata_s)
    );

    // Write channel FSM: address capture, beat counting and response generation.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wstate_r    <= W_IDLE;
            wid_r       <= {IDW{1'b0}};
            waddr_r     <= {AW{1'b0}};
            wlen_r      <= 8'd0;
            wcnt_r      <= 8'd0;
            wsize_r     <= 3'd0;
            wincr_r     <= 1'b0;
            werr_r      <= 1'b0;
            wlast_err_r <= 1'b0;
            awready_r   <= 1'b0;
            wready_r    <= 1'b0;
            bvalid_r    <= 1'b0;
            bresp_r     <= RESP_OKAY;
        end else begin
            case (wstate_r)
                W_IDLE: begin
                    awready_r <= 1'b1;
                    if (aw_hs_s) begin
                        wid_r       <= S_AXI_AWID;
                        waddr_r     <= S_AXI_AWADDR;
                        wlen_r      <= S_AXI_AWLEN;
                        wsize_r     <= S_AXI_AWSIZE;
                        wincr_r     <= (S_AXI_AWBURST == BURST_INCR);
                        werr_r      <= burst_err(S_AXI_AWBURST, S_AXI_AWSIZE);
                        wcnt_r      <= 8'd0;
                        wlast_err_r <= 1'b0;
                        awready_r   <= 1'b0;
                        wready_r    <= 1'b1;
                        wstate_r    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs_s) begin
                        waddr_r <= step_addr(waddr_r, wsize_r, wincr_r);
                        wcnt_r  <= wcnt_r + 8'd1;
                        if (w_lastbad_s) begin
                            wlast_err_r <= 1'b1;
                        end
                        // Length is authoritative: a stray WLAST never shortens the burst.
                        if (w_final_s) begin
                            wready_r <= 1'b0;
                            bvalid_r <= 1'b1;
                            bresp_r  <= (werr_r || wlast_err_r || w_lastbad_s) ? RESP_SLVERR : RESP_OKAY;
                            wstate_r <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_hs_s) begin
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        wstate_r  <= W_IDLE;
                    end
                end
                default: begin
                    wstate_r <= W_IDLE;
                end
            endcase
        end
    end

    // Read channel FSM: registered RDATA/RRESP/RLAST, advanced one beat per R handshake.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rstate_r  <= R_IDLE;
            rid_r     <= {IDW{1'b0}};
            raddr_r   <= {AW{1'b0}};
            rlen_r    <= 8'd0;
            rcnt_r    <= 8'd0;
            rsize_r   <= 3'd0;
            rincr_r   <= 1'b0;
            rerr_r    <= 1'b0;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rresp_r   <= RESP_OKAY;
            rdata_r   <= {DW{1'b0}};
        end else begin
            case (rstate_r)
                R_IDLE: begin
                    arready_r <= 1'b1;
                    if (ar_hs_s) begin
                        rid_r     <= S_AXI_ARID;
                        rlen_r    <= S_AXI_ARLEN;
                        rsize_r   <= S_AXI_ARSIZE;
                        rincr_r   <= (S_AXI_ARBURST == BURST_INCR);
                        rerr_r    <= ar_err_s;
                        raddr_r   <= step_addr(S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARBURST == BURST_INCR);
                        rcnt_r    <= 8'd0;
                        rdata_r   <= ar_err_s ? {DW{1'b0}} : ram_rdata_s;
                        rresp_r   <= ar_err_s ? RESP_SLVERR : RESP_OKAY;
                        rlast_r   <= (S_AXI_ARLEN == 8'd0);
                        rvalid_r  <= 1'b1;
                        arready_r <= 1'b0;
                        rstate_r  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs_s) begin
                        if (rlast_r) begin
                            rvalid_r  <= 1'b0;
                            rlast_r   <= 1'b0;
                            arready_r <= 1'b1;
                            rstate_r  <= R_IDLE;
                        end else begin
                            rdata_r <= rerr_r ? {DW{1'b0}} : ram_rdata_s;
                            raddr_r <= step_addr(raddr_r, rsize_r, rincr_r);
                            rcnt_r  <= rcnt_r + 8'd1;
                            rlast_r <= ((rcnt_r + 8'd1) == rlen_r);
                        end
                    end
                end
                default: begin
                    rstate_r <= R_IDLE;
                end
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_BID     = wid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RID     = rid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = rresp_r;
    assign S_AXI_RLAST   = rlast_r;
    assign S_AXI_RVALID  = rvalid_r;

endmodule
